// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - scan states, anode codes and per-state output decode
package seven_seg_pkg;

  typedef enum logic [1:0] {S_D0, S_B0, S_D1, S_B1} scan_state_t;

  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

  function automatic logic [1:0] state_an(input scan_state_t s);
    case (s)
      S_D0:    return AN_D0;
      S_D1:    return AN_D1;
      default: return AN_OFF;
    endcase
  endfunction

  // Blank states already point the mux at the digit that comes next.
  function automatic logic state_mux(input scan_state_t s);
    return (s == S_D0) || (s == S_B1);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - dwell/dead-time counter with clear, enable and terminal compare
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign done = (cnt == term);

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - reserved

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - two-digit seven-segment scan scheduler; SEVSEG_DEADTIME_EN adds blanking
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DWELL = 24000,
  parameter int DEAD  = 480,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  output logic       mux_en,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int MAXV = (DWELL > DEAD) ? DWELL : DEAD;

  if (DWELL < 2) begin : g_bad_dwell
    $error("DWELL must be at least 2");
  end
  if (DEAD < 1) begin : g_bad_dead
    $error("DEAD must be at least 1");
  end
  if (MAXV - 1 > (2 ** CNT_W) - 1) begin : g_bad_width
    $error("CNT_W too narrow for max(DWELL,DEAD)-1");
  end

  scan_state_t      state, state_nxt;
  logic             started;
  logic [1:0]       an_q;
  logic [CNT_W-1:0] term;
  logic             done, cnt_en, adv;

  assign cnt_en = scan_en & started;
  assign adv    = cnt_en & done;

  always_comb begin
    state_nxt = state;
`ifdef SEVSEG_DEADTIME_EN
    case (state)
      S_D0: state_nxt = S_B0;
      S_B0: state_nxt = S_D1;
      S_D1: state_nxt = S_B1;
      S_B1: state_nxt = S_D0;
    endcase
    term = ((state == S_D0) || (state == S_D1)) ? CNT_W'(DWELL - 1) : CNT_W'(DEAD - 1);
`else
    case (state)
      S_D0:    state_nxt = S_D1;
      default: state_nxt = S_D0;
    endcase
    term = CNT_W'(DWELL - 1);
`endif
  end

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (reset),
    .clr  (adv),
    .en   (cnt_en),
    .term (term),
    .done (done)
  );

  // The first enabled edge after reset only lights digit 0 and counts as its
  // entry edge, so the opening dwell is as long as every later one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_D0;
      started    <= 1'b0;
      an_q       <= AN_OFF;
      mux_en     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (scan_en) begin
        if (!started) begin
          started <= 1'b1;
          an_q    <= state_an(state);
          mux_en  <= state_mux(state);
        end else if (done) begin
          state      <= state_nxt;
          an_q       <= state_an(state_nxt);
          mux_en     <= state_mux(state_nxt);
          frame_tick <= (state_nxt == S_D0);
        end
      end
    end
  end

  assign an = scan_en ? an_q : AN_OFF;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard bench for seven_seg_scan_ctrl at DWELL=4, DEAD=2
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_en = 1'b1;
  logic       mux_en;
  logic [1:0] an;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic prev_ft = 1'b0;

  seven_seg_scan_ctrl #(.DWELL(4), .DEAD(2), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .mux_en     (mux_en),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the edge and queue that cycle's outputs.
  task automatic cyc(input logic rst_v, input logic en, input logic [1:0] e_an,
                     input logic e_mux, input logic e_ft);
    @(posedge clk);
    #1;
    reset   = rst_v;
    scan_en = en;
    exp_q.push_back({e_an, e_mux, e_ft});
  endtask

  task automatic seg(input int n, input logic rst_v, input logic en, input logic [1:0] e_an,
                     input logic e_mux, input logic ft_first);
    for (int i = 0; i < n; i++)
      cyc(rst_v, en, e_an, e_mux, (i == 0) ? ft_first : 1'b0);
  endtask

  task automatic frame(input logic ft);
    seg(4, 1'b0, 1'b1, 2'b10, 1'b1, ft);
`ifdef SEVSEG_DEADTIME_EN
    seg(2, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
`endif
    seg(4, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
`ifdef SEVSEG_DEADTIME_EN
    seg(2, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
`endif
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({an, mux_en, frame_tick} !== e) begin
        bad++;
        $display("FAIL out_seq t=%0t got an=%b mux=%b ft=%b want an=%b mux=%b ft=%b",
                 $time, an, mux_en, frame_tick, e[3:2], e[1], e[0]);
      end
    end
    if (an === 2'b00) begin
      bad++;
      $display("FAIL an_both_on t=%0t got an=%b want never 00", $time, an);
    end
    if (prev_ft && frame_tick) begin
      bad++;
      $display("FAIL ft_double t=%0t got ft high 2 cycles want single pulse", $time);
    end
    prev_ft = frame_tick;
  end

  initial begin
    // reset then release: digit 0 lit for exactly DWELL cycles, no tick out of reset
    seg(3, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    seg(1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    frame(1'b0);
    frame(1'b1);
    frame(1'b1);

    // pause at cnt=2 of digit 1, then resume with exactly two lit cycles left
    seg(4, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
`ifdef SEVSEG_DEADTIME_EN
    seg(2, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
`endif
    seg(2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    seg(5, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    seg(2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
`ifdef SEVSEG_DEADTIME_EN
    seg(2, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
`endif
    frame(1'b1);

    // async reset between edges while mux_en=0
    seg(4, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
`ifdef SEVSEG_DEADTIME_EN
    seg(1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
`else
    seg(1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
`endif
    seg(3, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    seg(1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    frame(1'b0);
    frame(1'b1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
